axil_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that turns a simple command/response stream into AXI-Lite transactions on its m_axil_* port.
- Sits in front of the team's AXI-Lite RAM and other AXI-Lite slaves, where it acts as the bench-independent traffic source and the register-access engine for control logic.
- One transaction (read or write) is in flight at a time; the slave's response is returned on the rsp_* stream.

---
 rtl/axil_master.sv | 169 ++++++++++++++++
 tb/tb_axil_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// axil_master - single-outstanding AXI4-Lite initiator.
//
// Turns a command/response stream into one AXI-Lite read or write at a time.
// A command is accepted on cmd_valid & cmd_ready. The slave's response is
// returned on rsp_*, and rsp_* is held stable until rsp_ready.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   cmd_*               command stream (valid/ready, write, addr, wdata, wstrb)
//   rsp_*               response stream (valid/ready, write, rdata, resp)
//   m_axil_aw*/w*/b*    AXI-Lite write address, write data and write response
//   m_axil_ar*/r*       AXI-Lite read address and read data
module axil_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 16,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  // Every valid is decoded from registered state only, so no valid ever
  // depends combinationally on the matching ready.
  assign cmd_ready      = (state_q == IDLE) && rst;
  assign m_axil_awvalid = (state_q == WRITE) && !aw_done_q;
  assign m_axil_wvalid  = (state_q == WRITE) && !w_done_q;
  assign m_axil_bready  = (state_q == WRESP);
  assign m_axil_arvalid = (state_q == READ);
  assign m_axil_rready  = (state_q == RDATA);
  assign rsp_valid      = (state_q == RSP);

  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_arprot  = PROT;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;

  // NOTE: state uses non-blocking assignments and a reset sampled on the
  // clock edge, so every register updates together and reset has no
  // asynchronous path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // NOTE: each signal gets a hold-value default before the case statement.
  // This way no path leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        // AW and W complete independently. Move on once both have completed,
        // whether in the same cycle or in different cycles.
        aw_done_d = aw_done_q || (m_axil_awvalid && m_axil_awready);
        w_done_d  = w_done_q  || (m_axil_wvalid  && m_axil_wready);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axil_bvalid) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
          state_d     = RSP;
        end
      end
      READ: begin
        if (m_axil_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axil_rvalid) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master - directed bench for axil_master.
// A small behavioural AXI-Lite RAM acts as the slave. Its W-channel wait
// states and its error responses can be adjusted by the stimulus.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic        m_axil_arvalid, m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  axil_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // ---------------- slave model (AXI-Lite RAM) ----------------
  int          w_delay    = 0;      // cycles wvalid waits before wready
  logic [1:0]  b_resp_val = 2'b00;
  logic [1:0]  r_resp_val = 2'b00;
  logic [31:0] mem [0:255];
  int          w_cnt      = 0;
  logic        have_aw    = 1'b0, have_w = 1'b0;
  logic [15:0] aw_addr_s  = '0;
  logic [31:0] w_data_s   = '0;
  logic [3:0]  w_strb_s   = '0;
  logic        aw_hs, w_hs, ar_hs;
  logic [15:0] a_eff;
  logic [31:0] d_eff;
  logic [3:0]  s_eff;

  assign m_axil_awready = 1'b1;
  assign m_axil_arready = 1'b1;
  assign m_axil_wready  = (w_cnt >= w_delay);
  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;
  assign ar_hs = m_axil_arvalid && m_axil_arready;
  assign a_eff = aw_hs ? m_axil_awaddr : aw_addr_s;
  assign d_eff = w_hs ? m_axil_wdata : w_data_s;
  assign s_eff = w_hs ? m_axil_wstrb : w_strb_s;

  always @(posedge clk) begin
    if (!rst) begin
      m_axil_bvalid <= 1'b0;
      m_axil_rvalid <= 1'b0;
      m_axil_bresp  <= 2'b00;
      m_axil_rresp  <= 2'b00;
      m_axil_rdata  <= '0;
      have_aw       <= 1'b0;
      have_w        <= 1'b0;
      w_cnt         <= 0;
    end else begin
      if (m_axil_wvalid && !m_axil_wready) w_cnt <= w_cnt + 1;
      else if (w_hs) w_cnt <= 0;
      if (aw_hs) aw_addr_s <= m_axil_awaddr;
      if (w_hs) begin
        w_data_s <= m_axil_wdata;
        w_strb_s <= m_axil_wstrb;
      end
      if ((have_aw || aw_hs) && (have_w || w_hs) && !m_axil_bvalid) begin
        for (int i = 0; i < 4; i++)
          if (s_eff[i]) mem[a_eff[9:2]][8*i +: 8] <= d_eff[8*i +: 8];
        m_axil_bvalid <= 1'b1;
        m_axil_bresp  <= b_resp_val;
        have_aw       <= 1'b0;
        have_w        <= 1'b0;
      end else begin
        if (aw_hs) have_aw <= 1'b1;
        if (w_hs) have_w <= 1'b1;
        if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        m_axil_rvalid <= 1'b1;
        m_axil_rdata  <= mem[m_axil_araddr[9:2]];
        m_axil_rresp  <= r_resp_val;
      end else if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0;
      end
    end
  end

  // Handshake counters and a W-payload stability monitor.
  int          aw_hs_cnt  = 0, w_hs_cnt = 0, w_unstable = 0;
  logic        prev_wvalid = 1'b0;
  logic [31:0] prev_wdata  = '0;
  always @(posedge clk) begin
    if (aw_hs) aw_hs_cnt <= aw_hs_cnt + 1;
    if (w_hs) w_hs_cnt <= w_hs_cnt + 1;
    if (m_axil_wvalid && prev_wvalid && m_axil_wdata != prev_wdata)
      w_unstable <= w_unstable + 1;
    prev_wvalid <= m_axil_wvalid;
    prev_wdata  <= m_axil_wdata;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one command. Return at the first negedge where rsp_valid is high,
  // with lat = number of negedges after the accept edge. The response is
  // left unconsumed.
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output int lat);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops", rsp_valid, 0);
  endtask

  int lat, k, aw_base, w_base;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", m_axil_awvalid, 0);
    check("rst_wvalid", m_axil_wvalid, 0);
    check("rst_arvalid", m_axil_arvalid, 0);
    check("rst_bready", m_axil_bready, 0);
    check("rst_rready", m_axil_rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", m_axil_awaddr, 0);
    check("rst_wdata", m_axil_wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait write then read
    txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, lat);
    check("wr_latency", lat, 3);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_resp", rsp_resp, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    consume();
    txn(1'b0, 16'h0010, 32'h0, 4'h0, lat);
    check("rd_latency", lat, 3);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_rsp_resp", rsp_resp, 0);
    consume();

    // Byte strobes
    txn(1'b1, 16'h0020, 32'h11223344, 4'hF, lat);  consume();
    txn(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, lat); consume();
    txn(1'b0, 16'h0020, 32'h0, 4'h0, lat);
    check("strb_rdata", rsp_rdata, 32'h11BB33DD);
    consume();

    // AW accepted 3 cycles before W
    aw_base = aw_hs_cnt; w_base = w_hs_cnt;
    w_delay = 3;
    txn(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, lat);
    check("slow_w_latency", lat, 6);
    check("slow_w_aw_hs", aw_hs_cnt - aw_base, 1);
    check("slow_w_w_hs", w_hs_cnt - w_base, 1);
    check("slow_w_stable", w_unstable, 0);
    consume();
    check("slow_w_no_extra_rsp", rsp_valid, 0);
    w_delay = 0;
    txn(1'b0, 16'h0030, 32'h0, 4'h0, lat);
    check("slow_w_rdata", rsp_rdata, 32'hCAFEF00D);
    consume();

    // Response back-pressure for 5 cycles
    txn(1'b0, 16'h0010, 32'h0, 4'h0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold_rsp_write", rsp_write, 0);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    consume();
    check("hold_cmd_ready_after", cmd_ready, 1);

    // Error responses pass through
    b_resp_val = 2'b10;
    txn(1'b1, 16'h0040, 32'h01020304, 4'hF, lat);
    check("slverr_bresp", rsp_resp, 2'b10);
    consume();
    b_resp_val = 2'b00;
    r_resp_val = 2'b11;
    txn(1'b0, 16'h0040, 32'h0, 4'h0, lat);
    check("decerr_rresp", rsp_resp, 2'b11);
    consume();
    r_resp_val = 2'b00;

    // Reset while waiting in WRESP
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050;
    cmd_wdata = 32'h55667788; cmd_wstrb = 4'hF;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!m_axil_bready && k < 20) begin @(negedge clk); k++; end
    check("reached_wresp", m_axil_bready, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_awvalid", m_axil_awvalid, 0);
    check("mid_rst_wvalid", m_axil_wvalid, 0);
    check("mid_rst_bready", m_axil_bready, 0);
    check("mid_rst_arvalid", m_axil_arvalid, 0);
    check("mid_rst_rready", m_axil_rready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    check("mid_rst_no_rsp", rsp_valid, 0);
    txn(1'b1, 16'h0060, 32'h0BADCAFE, 4'hF, lat);
    check("post_rst_wr_latency", lat, 3);
    check("post_rst_wr_resp", rsp_resp, 0);
    consume();
    txn(1'b0, 16'h0060, 32'h0, 4'h0, lat);
    check("post_rst_rdata", rsp_rdata, 32'h0BADCAFE);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
